// File: rtl/conv_fft_pkg.sv
// Shared FSM state codes and output-select encoding for the 4-lane 2D-FFT image sequencer.
package conv_fft_pkg;
  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t DRAIN = 3'd2;
  localparam state_t FLUSH = 3'd3;
  localparam state_t DONE  = 3'd4;

  localparam int NUM_SEL = 8;
  localparam int SEL_W   = $clog2(NUM_SEL);

  // Lane-major, real before imaginary.
  localparam logic [SEL_W-1:0] SEL_L0_RE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_L0_IM = 3'd1;
  localparam logic [SEL_W-1:0] SEL_L1_RE = 3'd2;
  localparam logic [SEL_W-1:0] SEL_L1_IM = 3'd3;
  localparam logic [SEL_W-1:0] SEL_L2_RE = 3'd4;
  localparam logic [SEL_W-1:0] SEL_L2_IM = 3'd5;
  localparam logic [SEL_W-1:0] SEL_L3_RE = 3'd6;
  localparam logic [SEL_W-1:0] SEL_L3_IM = 3'd7;
endpackage

// File: rtl/rd_align_pipe.sv
// Delays read-issue valid and select code by the bank read latency so select lines up with bank data.
module rd_align_pipe
  import conv_fft_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_sel,
  output logic             any_valid
);
  logic [RD_LAT-1:0] vld;
  logic [SEL_W-1:0]  sel_q [RD_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) sel_q[i] <= '0;
    end else begin
      vld[0]   <= issue;
      sel_q[0] <= sel;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i]   <= vld[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_sel   = sel_q[RD_LAT-1];
  assign any_valid = |vld;
endmodule

// File: rtl/conv_fft_seq_ctrl.sv
// Job sequencer: loads ctx_length cachelines through the FFT lanes into the banks, then
// drains every stored entry once per select code, paced by the output FIFO.
module conv_fft_seq_ctrl
  import conv_fft_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   ctx_length,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fft_next,
  input  logic              fft_next_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [SEL_W-1:0]  select,
  output logic              output_valid,
  input  logic              output_fifo_full,
  output logic              overflow_err
);
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  state_t            state;
  logic [ADDR_W:0]   len_q, adm_cnt, acc_cnt, wr_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [SEL_W-1:0]  sel;
  logic              we_q, ovf_q;
  logic              accept, issue, last_entry, pipe_busy;
  logic [ADDR_W:0]   last_idx;

  assign last_idx   = len_q - 1'b1;
  assign in_ready   = (state == LOAD) && (adm_cnt < len_q);
  assign fft_next   = in_valid & in_ready;
  // A lane result is only written while a slot for it remains in this job.
  assign accept     = fft_next_out && (state == LOAD) && (acc_cnt < len_q);
  assign issue      = (state == DRAIN) && !output_fifo_full;
  assign last_entry = ({1'b0, rd_addr} == last_idx);

  assign busy              = (state == LOAD) || (state == DRAIN) || (state == FLUSH);
  assign done              = (state == DONE);
  assign mem_we            = we_q;
  assign mem_write_address = wr_addr;
  assign mem_read_address  = rd_addr;
  assign overflow_err      = ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      len_q   <= '0;
      adm_cnt <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      sel     <= SEL_L0_RE;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= accept;
      case (state)
        IDLE: if (start) begin
          len_q   <= sat_len(ctx_length);
          adm_cnt <= '0;
          acc_cnt <= '0;
          wr_cnt  <= '0;
          wr_addr <= '0;
          rd_addr <= '0;
          sel     <= SEL_L0_RE;
          ovf_q   <= 1'b0;
          state   <= (sat_len(ctx_length) == '0) ? DONE : LOAD;
        end
        LOAD: begin
          if (fft_next) adm_cnt <= adm_cnt + 1'b1;
          if (accept)   acc_cnt <= acc_cnt + 1'b1;
          // Write count, not address, ends the phase so a full-depth job can wrap the address.
          if (we_q) begin
            wr_addr <= wr_addr + 1'b1;
            wr_cnt  <= wr_cnt + 1'b1;
            if (wr_cnt == last_idx) state <= DRAIN;
          end
        end
        DRAIN: if (issue) begin
          if (sel == SEL_L3_IM) begin
            sel <= SEL_L0_RE;
            if (last_entry) state <= FLUSH;
            else            rd_addr <= rd_addr + 1'b1;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        FLUSH: if (!pipe_busy) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fft_next_out && !accept) ovf_q <= 1'b1;
    end
  end

  rd_align_pipe #(.RD_LAT(RD_LAT)) u_rd_align (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     (issue),
    .sel       (sel),
    .out_valid (output_valid),
    .out_sel   (select),
    .any_valid (pipe_busy)
  );
endmodule

// File: tb/tb_conv_fft_seq_ctrl.sv
// Scoreboard bench for conv_fft_seq_ctrl: directed jobs push expected writes/reads, a monitor checks them.
module tb_conv_fft_seq_ctrl;
  localparam int ADDR_W   = 3;
  localparam int RD_LAT   = 1;
  localparam int LANE_LAT = 10;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   ctx_length = '0;
  logic              in_valid = 1'b0;
  logic              output_fifo_full = 1'b0;
  logic              force_out = 1'b0;
  logic              fft_next_out;
  logic              busy, done, in_ready, fft_next, mem_we, output_valid, overflow_err;
  logic [ADDR_W-1:0] mem_write_address, mem_read_address;
  logic [2:0]        select;
  logic [LANE_LAT-1:0] lane_sr = '0;
  logic [ADDR_W-1:0] prev_rd = '0;

  int tests = 0, fails = 0;
  int out_cnt = 0, done_cnt = 0, next_cnt = 0, d0 = 0, e_val = 0;
  int exp_q[$];
  int wexp_q[$];

  conv_fft_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .ctx_length        (ctx_length),
    .busy              (busy),
    .done              (done),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .fft_next          (fft_next),
    .fft_next_out      (fft_next_out),
    .mem_we            (mem_we),
    .mem_write_address (mem_write_address),
    .mem_read_address  (mem_read_address),
    .select            (select),
    .output_valid      (output_valid),
    .output_fifo_full  (output_fifo_full),
    .overflow_err      (overflow_err)
  );

  always #5 clk = ~clk;

  // Fixed-latency model of the four lockstep FFT lanes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lane_sr <= '0;
    else          lane_sr <= {lane_sr[LANE_LAT-2:0], fft_next};
  end
  assign fft_next_out = lane_sr[LANE_LAT-1] | force_out;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (output_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got output_valid=1 sel=%0d, want no output", select);
        end else begin
          e_val = exp_q.pop_front();
          check("out_sel", int'(select), e_val % 8);
          check("out_addr", int'(prev_rd), e_val / 8);
        end
      end
      if (mem_we) begin
        if (wexp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_we: got mem_we=1 addr=%0d, want no write", mem_write_address);
        end else begin
          check("wr_addr", int'(mem_write_address), wexp_q.pop_front());
        end
      end
      if (output_valid || mem_we) check("we_out_overlap", int'(output_valid & mem_we), 0);
      if (fft_next) next_cnt++;
      if (done) begin
        done_cnt++;
        check("done_busy", int'(busy), 0);
      end
    end
    prev_rd = mem_read_address;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    ctx_length = l[ADDR_W:0];
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_job(input int l);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    for (int a = 0; a < n; a++) wexp_q.push_back(a);
    for (int a = 0; a < n; a++)
      for (int s = 0; s < 8; s++) exp_q.push_back(a * 8 + s);
  endtask

  task automatic wait_done(input int budget, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_cnt < n; i++) tick(1);
    check("wait_out", int'(out_cnt >= n), 1);
  endtask

  initial begin
    tick(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_valid", int'(output_valid), 0);
    check("rst_ovf", int'(overflow_err), 0);
    reset_n = 1'b1;
    tick(1);

    // Basic two-entry job.
    push_job(2); out_cnt = 0; next_cnt = 0; d0 = done_cnt;
    do_start(2);
    check("basic_busy", int'(busy), 1);
    in_valid = 1'b1; tick(6); in_valid = 1'b0;
    wait_done(200, "basic_done");
    check("basic_outs", out_cnt, 16);
    check("basic_next", next_cnt, 2);
    check("basic_q", exp_q.size(), 0);
    check("basic_wq", wexp_q.size(), 0);
    check("basic_ovf", int'(overflow_err), 0);
    tick(2);
    check("basic_done_cnt", done_cnt - d0, 1);

    // Zero length.
    d0 = done_cnt; out_cnt = 0;
    do_start(0);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    tick(1);
    check("zero_done_end", int'(done), 0);
    check("zero_busy2", int'(busy), 0);
    tick(3);
    check("zero_done_cnt", done_cnt - d0, 1);
    check("zero_outs", out_cnt, 0);

    // Overrun: extra input, then a stray lane result.
    push_job(3); out_cnt = 0; next_cnt = 0;
    do_start(3);
    in_valid = 1'b1; tick(5); in_valid = 1'b0;
    check("ovr_next", next_cnt, 3);
    check("ovr_ready", int'(in_ready), 0);
    for (int i = 0; i < 60 && mem_write_address != 3; i++) tick(1);
    check("ovr_waddr3", int'(mem_write_address), 3);
    force_out = 1'b1; tick(1); force_out = 1'b0;
    check("ovr_err", int'(overflow_err), 1);
    tick(1);
    check("ovr_waddr_hold", int'(mem_write_address), 3);
    wait_done(200, "ovr_done");
    check("ovr_outs", out_cnt, 24);
    check("ovr_err_sticky", int'(overflow_err), 1);

    // Backpressure on a one-entry job; the start also clears overflow_err.
    tick(1);
    push_job(1); out_cnt = 0;
    do_start(1);
    check("ovf_cleared", int'(overflow_err), 0);
    in_valid = 1'b1;
    wait_out(1, 100);
    output_fifo_full = 1'b1; tick(3); output_fifo_full = 1'b0;
    in_valid = 1'b0;
    wait_done(200, "bp_done");
    check("bp_outs", out_cnt, 8);
    check("bp_q", exp_q.size(), 0);

    // Clamp to full depth, start while busy ignored.
    tick(1);
    push_job(9); out_cnt = 0; d0 = done_cnt;
    do_start(9);
    in_valid = 1'b1; tick(3);
    start = 1'b1; ctx_length = 2; tick(1); start = 1'b0;
    tick(10); in_valid = 1'b0;
    wait_done(400, "clamp_done");
    check("clamp_outs", out_cnt, 64);
    check("clamp_q", exp_q.size(), 0);
    check("clamp_wq", wexp_q.size(), 0);
    check("clamp_waddr_wrap", int'(mem_write_address), 0);
    check("clamp_raddr_last", int'(mem_read_address), 7);
    tick(5);
    check("clamp_idle", int'(busy), 0);
    check("clamp_done_cnt", done_cnt - d0, 1);

    // Asynchronous reset in the middle of DRAIN.
    push_job(4); out_cnt = 0;
    do_start(4);
    in_valid = 1'b1; tick(6); in_valid = 1'b0;
    wait_out(3, 200);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_valid", int'(output_valid), 0);
    check("mid_select", int'(select), 0);
    check("mid_raddr", int'(mem_read_address), 0);
    check("mid_waddr", int'(mem_write_address), 0);
    check("mid_we", int'(mem_we), 0);
    check("mid_done", int'(done), 0);
    exp_q.delete();
    wexp_q.delete();
    tick(2);
    reset_n = 1'b1;
    out_cnt = 0;
    tick(20);
    check("mid_post_busy", int'(busy), 0);
    check("mid_post_outs", out_cnt, 0);
    check("mid_no_done", done_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule

// File: doc/conv_fft_seq_ctrl.md
Name: conv_fft_seq_ctrl

Overview:
Sequencer for the 4-lane 2D-FFT image datapath (four fft4_2d lanes feeding four memBlockImage banks).
- Runs one job per start pulse, in two phases.
- LOAD: admits ctx_length input cachelines into the FFT lanes and generates the bank write strobe and address.
- DRAIN: reads back every stored entry eight times, once per select code (lane 0..3, real then imaginary), paced by the output FIFO.
- Replaces the free-running counters inside the datapath top with an explicit FSM.

Parameters:
- ADDR_W, 13: bank address width; DEPTH = 2**ADDR_W entries.
- RD_LAT, 1: cycles from mem_read_address/issue to bank data valid at the select mux (1..4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- ctx_length  in  ADDR_W+1  job length in cachelines; captured at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- in_valid  in  1  host cacheline valid.
- in_ready  out  1  high in LOAD while admitted count < length.
- fft_next  out  1  in_valid & in_ready; drives the next input of all four lanes.
- fft_next_out  in  1  AND of the four lanes' next_out.
- mem_we  out  1  bank write enable.
- mem_write_address  out  ADDR_W  bank write address.
- mem_read_address  out  ADDR_W  bank read address.
- select  out  3  output mux code, aligned to bank data.
- output_valid  out  1  cacheline_out valid this cycle.
- output_fifo_full  in  1  almost-full from the output FIFO; must assert with at least RD_LAT+1 free slots.
- overflow_err  out  1  sticky: fft_next_out seen outside LOAD, or beyond length; cleared by start.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: busy, done, in_ready, fft_next, mem_we, both addresses, select, output_valid, overflow_err. All counters 0; the in-flight read pipeline is cleared.
- Length capture: len = min(ctx_length, DEPTH).
- IDLE:
  - start with len=0: go to DONE; done pulses on the next cycle; no writes, no reads.
  - start with len>0: go to LOAD; counters cleared; overflow_err cleared.
- LOAD:
  - in_ready = (adm_cnt < len); adm_cnt increments on fft_next.
  - mem_we is fft_next_out registered by one cycle.
  - mem_write_address increments on each mem_we cycle, starting at 0.
  - Go to DRAIN in the cycle after the mem_we with mem_write_address = len-1.
  - Extra in_valid is ignored (in_ready=0).
- DRAIN:
  - Each cycle with output_fifo_full=0, issue one read at (rd_addr, sel).
  - sel counts 0..7; on 7 it wraps to 0 and rd_addr increments. mem_read_address = rd_addr, so each address is held for 8 issues.
  - output_fifo_full=1 means no issue that cycle; rd_addr/sel hold.
  - The issue at (len-1, 7) moves the FSM to FLUSH.
- Output alignment:
  - output_valid = issue delayed RD_LAT cycles.
  - select = sel delayed RD_LAT cycles, so select matches the data it is presented with.
  - In-flight reads complete regardless of output_fifo_full (headroom is guaranteed by the almost-full threshold).
- FLUSH: wait until the delay pipeline holds no valid, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Output count: exactly 8*len output_valid pulses per job; order is address-major, select-minor.
- start while busy is ignored.
- fft_next_out with mem_write_address already at len, or outside LOAD: no write, overflow_err set.
- Simultaneous fft_next and fft_next_out in LOAD are both honoured (pipelined lanes).
- len = DEPTH: mem_write_address wraps to 0 only after the final write; the transition uses the write count, not the address.
- reset_n asserted mid-job: immediate abort, no done pulse.

Decomposition:
- Shared package (conv_fft_pkg):
  - state enum {IDLE, LOAD, DRAIN, FLUSH, DONE};
  - localparam NUM_SEL = 8;
  - select encoding constants SEL_L0_RE..SEL_L3_IM = 0..7.
- One sub-module, rd_align_pipe: RD_LAT-deep shift register carrying {valid, sel[2:0]}, asynchronously reset.

Test Plan:
- Reset: reset_n low mid-DRAIN with len=4 → all outputs 0 asynchronously; after release, busy=0 and no output_valid.
- Basic job: len=2, RD_LAT=1, FIFO never full, in_valid contiguous, lane latency 10 → mem_we at writes 0,1; 16 output_valid pulses with select 0..7,0..7; done pulse follows the last valid; output_valid never overlaps mem_we.
- Backpressure: len=1, output_fifo_full high for 3 cycles after the 2nd issue → selects still 0..7 in order, no duplicates or drops, exactly 8 valids.
- Zero length: start with ctx_length=0 → done on the next cycle, busy low throughout, no mem_we, no output_valid.
- Overrun: len=3, drive 5 in_valid → in_ready drops after 3; force a 4th fft_next_out → overflow_err=1, mem_write_address stays 3 (no 4th write); the next start clears overflow_err.
- Clamp/wrap: ADDR_W=3, ctx_length=9 → len=8, 64 outputs, last read address 7, done; start during busy ignored.
